line_buffer: RTL and testbench
==============================

LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 Parameter DATA_W, default 64, SHALL be the width in bits of one stored vector.
REQ-002 Parameter DEPTH, default 4096, SHALL be the maximum number of vectors stored, i.e. the maximum row length.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), SHALL be the write/read pointer width.
REQ-004 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 curr_width  input  32  SHALL give the active row length in vectors (delay length).
REQ-007 pixel  input  DATA_W  SHALL be the vector written when data_valid is high.
REQ-008 data_valid  input  1  SHALL be the write/advance strobe; one vector per high cycle.
REQ-009 o_data  output  DATA_W  SHALL carry the vector written exactly L valid writes earlier (registered).

Function
REQ-010 Effective length L SHALL be: 1 if curr_width <= 1; DEPTH if curr_width >= DEPTH; otherwise curr_width.
REQ-011 The block SHALL hold a circular memory of DEPTH x DATA_W entries and a pointer ptr.
REQ-012 On a clock edge with data_valid=1, it SHALL read before write:
- o_data <= mem[ptr]
- mem[ptr] <= pixel
REQ-013 On the same edge, ptr SHALL advance: ptr <= 0 if ptr >= L-1, else ptr+1.
REQ-014 The >= compare SHALL make a curr_width decrease take effect without ptr running past L-1.
REQ-015 With data_valid=0, ptr, memory and o_data SHALL hold their values.
REQ-016 Latency SHALL be one clock edge:
- o_data updates on the edge that accepts the write.
- It then shows the pixel accepted L writes before the current one, i.e. the same column of the previous row.
REQ-017 For L=1, o_data SHALL equal the pixel accepted on the previous valid edge.
REQ-018 Gaps in data_valid SHALL NOT affect ordering; the delay counts valid writes, not cycles.
REQ-019 No combinational path SHALL exist from any input to o_data.
REQ-020 The memory SHALL have one read port and one write port at the same address, so it can map to block RAM.

Reset
REQ-021 Synchronous rst=1 SHALL set ptr=0 and o_data=0.
REQ-022 rst SHALL take priority over data_valid; a write presented during reset is discarded.
REQ-023 rst SHALL NOT clear the memory contents.
REQ-024 Reset mid-row SHALL restart addressing at entry 0 on the first valid edge after rst falls.

Configuration
REQ-025 Macro LINE_BUFFER_ZERO_INIT_EN SHALL control power-up memory contents:
- Defined: every memory entry is initialised to 0 at time zero, so the first L reads after power-up return 0.
- Undefined: there is no initialiser, and reads of never-written entries are don't-care.

Verification
REQ-026 Basic delay: LINE_BUFFER_ZERO_INIT_EN defined, curr_width=4, write pixels 1..12 on consecutive valid cycles -> o_data after each write is 0,0,0,0,1,2,...,8.
REQ-027 Gapped valid: curr_width=3, pixels 0xA,0xB,0xC,0xD with 2 idle cycles between writes -> o_data holds during gaps; after 0xD it is 0xA.
REQ-028 Width 1 and width 0: curr_width=1, then repeat with curr_width=0, write 5,6,7 -> o_data is 0,5,6 in both cases.
REQ-029 Reset mid-stream: curr_width=4, write 1..6, assert rst one cycle with data_valid=1 and pixel=99 -> o_data=0, ptr=0, 99 not stored; next write of 7 -> o_data equals old mem[0]=5.
REQ-030 Shrink and clamp:
- curr_width changes 8 -> 3 while ptr=6 -> next write wraps ptr to 0.
- curr_width=DEPTH+10 -> delay equals DEPTH.

Source files
------------

// File: rtl/line_buffer.sv
// Row delay line: o_data shows the vector written L valid writes earlier (L from curr_width, clamped to 1..DEPTH).
// Define LINE_BUFFER_ZERO_INIT_EN to power the memory up as all zeros; otherwise its power-up contents are undefined.
module line_buffer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       curr_width,
  input  logic [DATA_W-1:0] pixel,
  input  logic              data_valid,
  output logic [DATA_W-1:0] o_data
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

`ifdef LINE_BUFFER_ZERO_INIT_EN
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
`else
  logic [DATA_W-1:0] mem [DEPTH];
`endif

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next_c;
  logic [31:0]       len_c;
  logic [31:0]       last_c;

  // Effective length, then wrap with >= so that shrinking curr_width never lets ptr run past the end.
  always_comb begin
    len_c = curr_width;
    if (curr_width <= 32'd1) begin
      len_c = 32'd1;
    end else if (curr_width >= DEPTH_W) begin
      len_c = DEPTH_W;
    end
    last_c     = len_c - 32'd1;
    ptr_next_c = ptr + ADDR_W'(1);
    if (32'(ptr) >= last_c) begin
      ptr_next_c = '0;
    end
  end

  // Pointer and registered output; reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      o_data <= '0;
    end else if (data_valid) begin
      ptr    <= ptr_next_c;
      o_data <= mem[ptr];
    end
  end

  // Memory write port has no reset so it can map to block RAM.
  always_ff @(posedge clk) begin
    if (data_valid && !rst) begin
      mem[ptr] <= pixel;
    end
  end

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer; the memory is flushed with zeros before each scenario so expectations hold with or without power-up zeroing.
module tb_line_buffer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic [31:0]       curr_width;
  logic [DATA_W-1:0] pixel;
  logic              data_valid;
  logic [DATA_W-1:0] o_data;

  int n_tests;
  int n_fail;

  line_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .curr_width (curr_width),
    .pixel      (pixel),
    .data_valid (data_valid),
    .o_data     (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic dv, input logic [DATA_W-1:0] pix, input logic r);
    @(negedge clk);
    data_valid = dv;
    pixel      = pix;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_chk(input string tag, input logic [DATA_W-1:0] pix, input logic [DATA_W-1:0] exp);
    step(1'b1, pix, 1'b0);
    check(tag, o_data, exp);
  endtask

  // Fill every entry with zero, then reset so ptr and o_data restart at 0.
  task automatic flush;
    curr_width = 32'(DEPTH);
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    data_valid = 1'b0;
    pixel      = '0;
    curr_width = 32'd4;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    check("reset_o_data", o_data, '0);

    // Basic delay of 4.
    flush();
    curr_width = 32'd4;
    for (int i = 1; i <= 12; i++) begin
      wr_chk("basic", DATA_W'(i), (i <= 4) ? '0 : DATA_W'(i - 4));
    end

    // Gaps in valid: output holds, delay counts writes only.
    flush();
    curr_width = 32'd3;
    wr_chk("gap_w0", 16'hA, '0);
    step(1'b0, 16'h55, 1'b0); check("gap_hold0", o_data, '0);
    step(1'b0, 16'h55, 1'b0);
    wr_chk("gap_w1", 16'hB, '0);
    step(1'b0, 16'h55, 1'b0);
    step(1'b0, 16'h55, 1'b0);
    wr_chk("gap_w2", 16'hC, '0);
    step(1'b0, 16'h55, 1'b0);
    step(1'b0, 16'h55, 1'b0);
    wr_chk("gap_w3", 16'hD, 16'hA);
    step(1'b0, 16'h55, 1'b0); check("gap_hold3", o_data, 16'hA);
    step(1'b0, 16'h55, 1'b0);
    wr_chk("gap_w4", 16'hE, 16'hB);

    // Width 1 and width 0 both behave as a one-write delay.
    flush();
    curr_width = 32'd1;
    wr_chk("w1_a", 16'd5, 16'd0);
    wr_chk("w1_b", 16'd6, 16'd5);
    wr_chk("w1_c", 16'd7, 16'd6);
    flush();
    curr_width = 32'd0;
    wr_chk("w0_a", 16'd5, 16'd0);
    wr_chk("w0_b", 16'd6, 16'd5);
    wr_chk("w0_c", 16'd7, 16'd6);

    // Reset mid-stream: memory kept, write during reset dropped, addressing restarts at 0.
    flush();
    curr_width = 32'd4;
    for (int i = 1; i <= 6; i++) begin
      wr_chk("rst_pre", DATA_W'(i), (i <= 4) ? '0 : DATA_W'(i - 4));
    end
    step(1'b1, 16'd99, 1'b1);
    check("rst_mid_o_data", o_data, '0);
    wr_chk("rst_post0", 16'd7, 16'd5);
    wr_chk("rst_post1", 16'd8, 16'd6);
    wr_chk("rst_post2", 16'd9, 16'd3);
    wr_chk("rst_post3", 16'd10, 16'd4);
    wr_chk("rst_post4", 16'd11, 16'd7);

    // Shrink 8 -> 3 with ptr at 6: next write wraps to 0.
    flush();
    curr_width = 32'd8;
    for (int i = 1; i <= 6; i++) wr_chk("shrink_pre", DATA_W'(i), '0);
    curr_width = 32'd3;
    wr_chk("shrink_w6", 16'd20, 16'd0);
    wr_chk("shrink_w0", 16'd21, 16'd1);
    wr_chk("shrink_w1", 16'd22, 16'd2);
    wr_chk("shrink_w2", 16'd23, 16'd3);
    wr_chk("shrink_wrap", 16'd24, 16'd21);

    // Oversize width clamps the delay to DEPTH.
    flush();
    curr_width = 32'(DEPTH + 10);
    for (int i = 1; i <= int'(DEPTH) + 3; i++) begin
      wr_chk("clamp", DATA_W'(i), (i <= int'(DEPTH)) ? '0 : DATA_W'(i - int'(DEPTH)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
